// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative radix-2 shift-add multiplier, unsigned or two's-complement,
// one word_width-iteration multiply per start/done transaction.
module fast_adder #(
  parameter int WIDTH        = 16,
  parameter int CASCADE_SIZE = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c,
  output logic [WIDTH-1:0] o_s,
  output logic             o_c
);
  localparam int N = WIDTH / CASCADE_SIZE;
  logic [N:0] w_c;
  assign w_c[0] = i_c;
  assign o_c    = w_c[N];
  // Carry-select: each group precomputes both carry-in outcomes
  for (genvar g = 0; g < N; g++) begin : g_blk
    logic [CASCADE_SIZE:0] w_s0, w_s1;
    assign w_s0 = {1'b0, i_a[g*CASCADE_SIZE +: CASCADE_SIZE]} + {1'b0, i_b[g*CASCADE_SIZE +: CASCADE_SIZE]};
    assign w_s1 = w_s0 + (CASCADE_SIZE+1)'(1);
    assign {w_c[g+1], o_s[g*CASCADE_SIZE +: CASCADE_SIZE]} = w_c[g] ? w_s1 : w_s0;
  end
endmodule

// polyshift_r: double-precision right shift, i_fill enters at the msb end.
module polyshift_r #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_SIZE = 1
) (
  input  logic [WIDTH-1:0]      i_data,
  input  logic [SHIFT_SIZE-1:0] i_fill,
  output logic [WIDTH-1:0]      o_data
);
  assign o_data = {i_fill, i_data[WIDTH-1:SHIFT_SIZE]};
endmodule

module seq_multiplier #(
  parameter int word_width    = 16,
  parameter int adder_cascade = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      is_signed,
  input  logic [word_width-1:0]     A,
  input  logic [word_width-1:0]     B,
  output logic                      busy,
  output logic                      done,
  output logic [2*word_width-1:0]   R
);
  localparam int W  = word_width;
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t r_state, w_next;
  logic [W-1:0]  r_m, r_h, r_l, w_add, w_s, w_h, w_l;
  logic          r_neg, w_c, w_accept;
  logic [CW-1:0] r_cnt;
  assign w_accept = start & (r_state == IDLE || r_state == DONE);
  assign w_add    = r_l[0] ? r_m : '0;
  assign busy     = r_state == RUN || r_state == FIX;
  assign done     = r_state == DONE;
  fast_adder #(.WIDTH(W), .CASCADE_SIZE(adder_cascade)) u_add (
    .i_a(r_h), .i_b(w_add), .i_c(1'b0), .o_s(w_s), .o_c(w_c)
  );
  polyshift_r #(.WIDTH(2*W), .SHIFT_SIZE(1)) u_shift (
    .i_data({w_s, r_l}), .i_fill(w_c), .o_data({w_h, w_l})
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_next = (r_state == RUN) ? ((r_cnt == CW'(W-1)) ? FIX : RUN) :
             (r_state == FIX) ? DONE :
             w_accept         ? RUN  : IDLE;
  end
  // Operands are stored as magnitudes; the sign is reapplied once at FIX
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_m   <= '0;
      r_h   <= '0;
      r_l   <= '0;
      r_neg <= 1'b0;
      r_cnt <= '0;
      R     <= '0;
    end else if (w_accept) begin
      r_m   <= (is_signed & A[W-1]) ? -A : A;
      r_l   <= (is_signed & B[W-1]) ? -B : B;
      r_h   <= '0;
      r_neg <= is_signed & (A[W-1] ^ B[W-1]);
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_h   <= w_h;
      r_l   <= w_l;
      r_cnt <= r_cnt + 1'b1;
    end else if (r_state == FIX) begin
      R <= r_neg ? -{r_h, r_l} : {r_h, r_l};
    end
  end
endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Iterative radix-2 shift-add multiplier for the ALU execute stage.
- Accumulates partial products with fast_adder and performs the double-precision right shift with polyshift_r (shift_type DOUBLE_PECISION, shift_size 1).
- Accepts one operand pair per start/done transaction and produces a full-width 2×word_width product.
- Supports unsigned and two's-complement signed operands.

Parameters:
- word_width, 16: operand width in bits. Must equal adder_cascade^k with k≥1.
- adder_cascade, 4: cascade_size passed to the internal fast_adder instance.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset. Asserting it (0) immediately clears all state.
- start, input, 1: request a multiply. Sampled only while busy=0.
- is_signed, input, 1: 1 treats A and B as two's complement; 0 treats them as unsigned. Sampled with start.
- A, input, word_width: multiplicand.
- B, input, word_width: multiplier.
- busy, output, 1: a multiply is in progress.
- done, output, 1: single-cycle pulse. R is valid in this cycle.
- R, output, 2*word_width: product, held until the next accepted start.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, R=0.
  - Iteration counter and internal accumulators are cleared.
  - Reset taken mid-operation aborts the operation. No done is produced.
  - After release, the block is idle on the next clk edge.
- States: IDLE, RUN, FIX, DONE.
- IDLE, and the DONE cycle (back-to-back allowed): on a clk edge with start=1, the block latches the operation.
  - Multiplicand register M = |A| if is_signed, else A.
  - Low accumulator L = |B| if is_signed, else B.
  - High accumulator H = 0.
  - neg = is_signed & (A[msb] ^ B[msb]).
  - Counter = 0. busy goes 1. Next state is RUN.
  - |x| of the most negative value is 2^(word_width-1), which is representable unsigned. No special case.
- RUN: one iteration per edge, word_width iterations in total.
  - {c, S} = fast_adder(H, L[0] ? M : 0, C_IN=0).
  - {H, L} ← double-precision right shift by 1 of {c, S, L}: carry enters H msb, S lsb enters L msb.
  - Counter increments. When counter reaches word_width-1 on this edge, next state is FIX.
- FIX: one edge.
  - R ← neg ? -{H, L} (two's complement, 2*word_width bits) : {H, L}.
  - Next state is DONE. done=1 and busy=0 take effect on this edge.
- DONE: the one cycle where done=1.
  - The next edge returns to IDLE, or accepts start as described above.
- Latency:
  - Start is accepted at edge E.
  - The final RUN iteration completes at edge E+word_width.
  - done=1 is asserted in the cycle following edge E+word_width+1.
  - Total is word_width+1 edges after acceptance.
- busy is 1 from edge E through edge E+word_width+1 (exclusive), and 0 during done.
- While busy=1, start, A, B and is_signed are ignored. Changing them has no effect.
- R is registered and changes only at the FIX edge, or when reset is asserted. R holds its value through IDLE and through the next operation until that operation's FIX edge.
- No overflow is possible: the 2*word_width product is always exact.
- Zero operand(s) follow the normal path and take the full latency. There is no early termination.

Test Plan (word_width=16):
- Unsigned small operands: reset pulse, then start with A=3, B=5, is_signed=0 → busy=1 for 17 edges, done single pulse, R=0x0000000F, busy=0 while done=1.
- Signed mixed signs: A=0xFFFD (-3), B=5, is_signed=1 → R=0xFFFFFFF1. Then A=0xFFFD, B=0xFFFB → R=0x0000000F.
- Unsigned max and signed min: A=B=0xFFFF, is_signed=0 → R=0xFFFE0001. A=B=0x8000, is_signed=1 → R=0x40000000. A=0x8000, B=0x0001, is_signed=1 → R=0xFFFF8000.
- Start while busy: start A=2, B=7; at edge 5 pulse start with A=9, B=9 → ignored, R=0x0000000E. Then assert start during the done cycle with A=4, B=4 → accepted, next done with R=0x00000010, no idle gap.
- Reset mid-operation: start A=100, B=100; assert reset=0 asynchronously at edge 8 → busy, done and R go 0 immediately with no clock required. No done appears afterwards. A subsequent multiply of 6×7 gives R=0x0000002A.
- R hold: after 6×7 completes, start 3×3 and check R stays 0x0000002A until that operation's done, then becomes 0x00000009.
